// File: rtl/ht_budget_tracker.sv
// ht_budget_tracker: head-tail table registers for the write-guard monitor,
// plus the free vector / first-free index derived from them and the prescaled,
// saturating sum of outstanding burst lengths used to scale timeout budgets.
module ht_budget_tracker #(
    parameter int unsigned HtCapacity   = 8,
    parameter int unsigned MaxTxns      = 8,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned LenWidth     = 8,
    parameter int unsigned CntWidth     = 8,
    parameter int unsigned PrescalerDiv = 1,
    // Derived; leave at their defaults.
    parameter int unsigned LdIdxWidth   = (MaxTxns > 1) ? $clog2(MaxTxns) : 1,
    parameter int unsigned HtIdxWidth   = (HtCapacity > 1) ? $clog2(HtCapacity) : 1,
    parameter int unsigned EntryWidth   = IdWidth + 2 * LdIdxWidth + 1,
    parameter int unsigned AccuCntWidth = CntWidth - $clog2(PrescalerDiv) + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [HtCapacity*EntryWidth-1:0]   ht_d_i,
    output logic [HtCapacity*EntryWidth-1:0]   ht_q_o,
    output logic [HtCapacity-1:0]              ht_free_o,
    output logic [HtIdxWidth-1:0]              ht_free_idx_o,
    output logic                               ht_full_o,
    input  logic [MaxTxns-1:0]                 ld_valid_i,
    input  logic [MaxTxns*LenWidth-1:0]        ld_len_i,
    output logic [AccuCntWidth-1:0]            accum_burst_len_o
);

    localparam int unsigned ShiftAmt = $clog2(PrescalerDiv);
    // Wide enough for MaxTxns * 2^LenWidth without overflow.
    localparam int unsigned SumWidth = LenWidth + 1 + $clog2(MaxTxns) + 1;
    // Common width for the saturation compare, one bit wider than either side.
    localparam int unsigned CmpWidth =
        ((SumWidth > AccuCntWidth) ? SumWidth : AccuCntWidth) + 1;

    // A free entry with all-zero fields is just the free bit set.
    localparam logic [EntryWidth-1:0] EntryReset = EntryWidth'(1);

    if ((PrescalerDiv == 0) || ((PrescalerDiv & (PrescalerDiv - 1)) != 0)) begin : g_bad_div
        $error("PrescalerDiv must be a power of two >= 1");
    end
    if ((HtCapacity == 0) || (MaxTxns == 0)) begin : g_bad_size
        $error("HtCapacity and MaxTxns must be >= 1");
    end

    logic [HtCapacity-1:0][EntryWidth-1:0] ht_d;
    logic [HtCapacity-1:0][EntryWidth-1:0] ht_q;
    logic [HtCapacity-1:0]                 ht_free;
    logic [HtIdxWidth-1:0]                 free_idx;
    logic [SumWidth-1:0]                   len_sum;
    logic [SumWidth-1:0]                   len_scaled;
    logic [CmpWidth-1:0]                   scaled_ext;
    logic [CmpWidth-1:0]                   sat_max;
    logic [AccuCntWidth-1:0]               accum;

    assign ht_d   = ht_d_i;
    assign ht_q_o = ht_q;

    // Table register: captured every cycle, synchronous reset clears to all-free.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ht_q <= {HtCapacity{EntryReset}};
        end else begin
            ht_q <= ht_d;
        end
    end

    // Free vector is the LSB of each registered entry.
    always_comb begin
        ht_free = '0;
        for (int unsigned i = 0; i < HtCapacity; i++) begin
            ht_free[i] = ht_q[i][0];
        end
    end

    // Priority encode, lowest free index wins; walking downwards lets the
    // last assignment be the lowest set bit. Stays 0 when the table is full.
    always_comb begin
        free_idx = '0;
        for (int i = int'(HtCapacity) - 1; i >= 0; i--) begin
            if (ht_free[i]) begin
                free_idx = HtIdxWidth'(i);
            end
        end
    end

    assign ht_free_o     = ht_free;
    assign ht_free_idx_o = free_idx;
    assign ht_full_o     = ~|ht_free;

    // Sum of (AxLEN + 1) over valid slots; invalid slots contribute nothing.
    always_comb begin
        len_sum = '0;
        for (int unsigned i = 0; i < MaxTxns; i++) begin
            if (ld_valid_i[i]) begin
                len_sum = len_sum + SumWidth'(ld_len_i[i*LenWidth +: LenWidth]) + SumWidth'(1);
            end
        end
    end

    // Prescale by floor division, then clamp to the output range so it never wraps.
    always_comb begin
        len_scaled = len_sum >> ShiftAmt;
        scaled_ext = CmpWidth'(len_scaled);
        sat_max    = CmpWidth'({AccuCntWidth{1'b1}});
        if (scaled_ext > sat_max) begin
            accum = sat_max[AccuCntWidth-1:0];
        end else begin
            accum = scaled_ext[AccuCntWidth-1:0];
        end
    end

    assign accum_burst_len_o = accum;

endmodule

// File: tb/tb_ht_budget_tracker.sv
// Scoreboard bench for ht_budget_tracker: a stimulus process drives inputs and
// pushes expected outputs from a table/arithmetic model; a negedge monitor pops
// and compares. Two DUTs share inputs: PrescalerDiv=1 and PrescalerDiv=4.
module tb_ht_budget_tracker;

    localparam int HtCap = 8;
    localparam int MaxT  = 8;
    localparam int EW    = 11;
    localparam int HW    = HtCap * EW;
    localparam int LW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [HW-1:0]        ht_d;
    logic [MaxT-1:0]      ld_valid;
    logic [MaxT*LW-1:0]   ld_len;

    logic [HW-1:0]        ht_q1, ht_q4;
    logic [HtCap-1:0]     free1, free4;
    logic [2:0]           idx1, idx4;
    logic                 full1, full4;
    logic [8:0]           acc1;
    logic [6:0]           acc4;

    ht_budget_tracker #(.PrescalerDiv(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .ht_d_i(ht_d), .ht_q_o(ht_q1),
        .ht_free_o(free1), .ht_free_idx_o(idx1), .ht_full_o(full1),
        .ld_valid_i(ld_valid), .ld_len_i(ld_len), .accum_burst_len_o(acc1)
    );

    ht_budget_tracker #(.PrescalerDiv(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .ht_d_i(ht_d), .ht_q_o(ht_q4),
        .ht_free_o(free4), .ht_free_idx_o(idx4), .ht_full_o(full4),
        .ld_valid_i(ld_valid), .ld_len_i(ld_len), .accum_burst_len_o(acc4)
    );

    typedef struct {
        string           name;
        logic [HW-1:0]   ht;
        logic [HtCap-1:0] free;
        logic [2:0]      idx;
        logic            full;
        logic [8:0]      acc1;
        logic [6:0]      acc4;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference table: one record per entry.
    int m_id[HtCap];
    int m_head[HtCap];
    int m_tail[HtCap];
    bit m_free[HtCap];

    task automatic chk(input string nm, input string what,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int id, input int head, input int tail,
                                          input bit fr);
        return {4'(id), 3'(head), 3'(tail), fr};
    endfunction

    // Table with distinct nonzero fields; free bit of entry i from mask[i].
    function automatic logic [HW-1:0] tbl(input logic [HtCap-1:0] mask);
        logic [HW-1:0] t;
        for (int i = 0; i < HtCap; i++) t[i*EW +: EW] = ent(i + 1, i, 7 - i, mask[i]);
        return t;
    endfunction

    function automatic logic [HW-1:0] rand_tbl();
        logic [HW-1:0] t;
        for (int i = 0; i < HtCap; i++)
            t[i*EW +: EW] = ent(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        return t;
    endfunction

    // Plain arithmetic: sum of len+1 over valid slots, floor-divide, clamp.
    function automatic int model_acc(input int div, input int aw);
        int sum = 0;
        for (int i = 0; i < MaxT; i++)
            if (ld_valid[i]) sum += int'(ld_len[i*LW +: LW]) + 1;
        sum = sum / div;
        if (sum > (1 << aw) - 1) sum = (1 << aw) - 1;
        return sum;
    endfunction

    // Apply what the DUT saw at the edge that just happened.
    task automatic model_clock();
        logic [EW-1:0] e;
        for (int i = 0; i < HtCap; i++) begin
            if (!rst_n) begin
                m_id[i] = 0; m_head[i] = 0; m_tail[i] = 0; m_free[i] = 1'b1;
            end else begin
                e = ht_d[i*EW +: EW];
                m_id[i]   = int'(e[10:7]);
                m_head[i] = int'(e[6:4]);
                m_tail[i] = int'(e[3:1]);
                m_free[i] = e[0];
            end
        end
    endtask

    task automatic drive(input logic r, input logic [HW-1:0] hd, input logic [MaxT-1:0] v,
                         input logic [MaxT*LW-1:0] l, input string nm);
        exp_t e;
        bit found;
        @(posedge clk);
        model_clock();
        #1;
        rst_n = r; ht_d = hd; ld_valid = v; ld_len = l;
        e.name = nm;
        found  = 1'b0;
        e.idx  = 3'd0;
        for (int i = 0; i < HtCap; i++) begin
            e.ht[i*EW +: EW] = ent(m_id[i], m_head[i], m_tail[i], m_free[i]);
            e.free[i] = m_free[i];
            if (m_free[i] && !found) begin
                e.idx = 3'(i);
                found = 1'b1;
            end
        end
        e.full = !found;
        e.acc1 = 9'(model_acc(1, 9));
        e.acc4 = 7'(model_acc(4, 7));
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "ht_q",  128'(ht_q1), 128'(e.ht));
            chk(e.name, "free",  128'(free1), 128'(e.free));
            chk(e.name, "idx",   128'(idx1),  128'(e.idx));
            chk(e.name, "full",  128'(full1), 128'(e.full));
            chk(e.name, "acc1",  128'(acc1),  128'(e.acc1));
            chk(e.name, "acc4",  128'(acc4),  128'(e.acc4));
            chk(e.name, "ht_q4", 128'(ht_q4), 128'(e.ht));
            chk(e.name, "idx4",  128'(idx4),  128'(e.idx));
        end
    end

    initial begin
        logic [HW-1:0] cap;
        logic [MaxT*LW-1:0] rl;
        rst_n = 1'b0; ht_d = rand_tbl(); ld_valid = '0; ld_len = '0;
        cap = '0;
        for (int i = 0; i < HtCap; i++) cap[i*EW +: EW] = ent(0, 0, 0, 1'b1);
        cap[2*EW +: EW] = ent(5, 3, 6, 1'b0);

        drive(1'b0, rand_tbl(), 8'h00, '0, "reset");
        drive(1'b1, cap,        8'h00, '0, "reset_hold");
        drive(1'b1, tbl(8'hE0), 8'h00, '0, "capture");
        drive(1'b1, tbl(8'h00), 8'h00, '0, "idx5");
        drive(1'b1, tbl(8'h80), 8'h00, '0, "full");
        drive(1'b1, tbl(8'h80), 8'b0000_1001, 64'h00000000_07000003, "idx7_acc12");
        drive(1'b1, tbl(8'h80), 8'b0000_1001, 64'h00000000_0700FF03, "acc_inval");
        drive(1'b1, tbl(8'h80), 8'h00, {8{8'hFF}}, "acc_none");
        drive(1'b1, tbl(8'h80), 8'hFF, {8{8'hFF}}, "acc_sat");
        drive(1'b1, tbl(8'h80), 8'b0000_0111, 64'h00000000_00040100, "presc8");
        drive(1'b1, tbl(8'h80), 8'b0000_1111, 64'h00000000_00040100, "presc9");
        drive(1'b0, rand_tbl(), 8'h00, '0, "midop_reset");
        drive(1'b1, rand_tbl(), 8'h00, '0, "after_reset");

        for (int n = 0; n < 300; n++) begin
            for (int s = 0; s < MaxT; s++) rl[s*LW +: LW] = 8'($urandom);
            drive(($urandom_range(0, 15) != 0), rand_tbl(), 8'($urandom), rl, "random");
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
